uart_rxd: RTL



---
 rtl/uart_rxd_pkg.sv | 30 +++
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rxd.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_rxd_pkg.sv
// Shared UART definitions: default line rate, divider helpers, receiver states.
// Both ends of the link derive their dividers from here.
package uart_rxd_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 9600;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_t;

  function automatic int baud_div(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  function automatic int half_div(
    input int clk_freq,
    input int baud
  );
    return baud_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Resets to 1 so an idle-high line does not look like an edge.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= 2'b11;
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_rxd.sv
// 8N1 UART receiver with mid-bit sampling, framing-error flag and
// break handling; one-cycle rxd_flag per good byte.
module uart_rxd
  import uart_rxd_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       rxd_pin,
  output logic [7:0] rxd_data,
  output logic       rxd_flag,
  output logic       rxd_err,
  output logic       rxd_busy
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int HALF_DIV = half_div(CLK_FREQ, BAUD);
  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  logic          rx_s;
  logic          rx_d;
  logic          fall;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  uart_sync u_sync (
    .clk (clk50M),
    .rst (rst),
    .d   (rxd_pin),
    .q   (rx_s)
  );

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      rx_d <= 1'b1;
    end else begin
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      rxd_data <= '0;
      rxd_flag <= 1'b0;
      rxd_err  <= 1'b0;
      rxd_busy <= 1'b0;
    end else begin
      rxd_flag <= 1'b0;
      rxd_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            cnt      <= '0;
            rxd_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // a start bit that is high again at mid-bit was a glitch
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state    <= IDLE;
              rxd_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rxd_data <= shreg;
              rxd_flag <= 1'b1;
              state    <= IDLE;
              rxd_busy <= 1'b0;
            end else begin
              rxd_err <= 1'b1;
              state   <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          // hold off until the line is released so a stuck-low
          // line cannot retrigger frames
          if (rx_s) begin
            state    <= IDLE;
            rxd_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rxd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
